// File: rtl/elc3_mmio_ctrl_pkg.sv
// Shared types and address-map constants for the eLC-3 memory/IO controller.
package elc3_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SRAM_ACC = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [15:0] IO_BASE       = 16'hFE00;
    localparam logic [8:0]  KBSR_OFS      = 9'h000;
    localparam logic [8:0]  KBDR_OFS      = 9'h002;
    localparam logic [8:0]  DISP_BASE_OFS = 9'h004;
    localparam int          DISP_STRIDE   = 4;

    localparam int KBSR_READY   = 15;
    localparam int KBSR_OVERRUN = 14;

endpackage

// File: rtl/elc3_mmio_ctrl_if.sv
// CPU-side request/ready bus between the eLC-3 datapath and the MMIO controller.
interface elc3_mmio_ctrl_if;
    logic        Mem_Req;
    logic        Mem_RW;
    logic [15:0] Addr;
    logic [15:0] Data_FromCPU;
    logic [15:0] Data_ToCPU;
    logic        Mem_Ready;

    modport master (
        output Mem_Req, Mem_RW, Addr, Data_FromCPU,
        input  Data_ToCPU, Mem_Ready
    );

    modport slave (
        input  Mem_Req, Mem_RW, Addr, Data_FromCPU,
        output Data_ToCPU, Mem_Ready
    );
endinterface

// File: rtl/elc3_mmio_ctrl_disp_chan.sv
// One display channel: data register, write strobe and busy timer behind DSR[15].
module elc3_disp_chan #(
    parameter int DISP_BUSY = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic [15:0] ddr,
    output logic [15:0] dsr,
    output logic        strobe
);
    localparam int CW = (DISP_BUSY > 1) ? $clog2(DISP_BUSY + 1) : 1;

    logic [CW-1:0] busy_cnt;
    logic          ready;

    // Data register and a strobe that lands in the DONE cycle of the write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ddr    <= '0;
            strobe <= 1'b0;
        end else begin
            strobe <= wr_en;
            if (wr_en)
                ddr <= wr_data;
        end
    end

    // Busy down-counter; a write while busy simply reloads it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy_cnt <= '0;
            ready    <= 1'b1;
        end else if (wr_en && DISP_BUSY > 0) begin
            busy_cnt <= CW'(DISP_BUSY);
            ready    <= 1'b0;
        end else if (busy_cnt != '0) begin
            busy_cnt <= busy_cnt - CW'(1);
            if (busy_cnt == CW'(1))
                ready <= 1'b1;
        end
    end

    assign dsr = {ready, 15'd0};
endmodule

// File: rtl/elc3_mmio_ctrl.sv
// eLC-3 memory/IO controller: request/ready handshake, SRAM with wait states,
// keyboard registers with overrun, and NUM_DISP display channels.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for Mem_Req; IO accesses complete on the sampling edge
// SRAM_ACC | SRAM controls asserted, wait counter running down to 0
// DONE     | Mem_Ready high for one cycle, then back to IDLE
module elc3_mmio_ctrl
    import elc3_mmio_pkg::*;
#(
    parameter int SRAM_ADDR_W = 20,
    parameter int SRAM_WAIT   = 2,
    parameter int NUM_DISP    = 1,
    parameter int DISP_BUSY   = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    elc3_mmio_ctrl_if.slave          bus,
    input  logic [15:0]              Kbd_Data,
    input  logic                     Kbd_Strobe,
    output logic [16*NUM_DISP-1:0]   Disp_Out,
    output logic [NUM_DISP-1:0]      Disp_Strobe,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_LB_N,
    output logic                     SRAM_UB_N,
    output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
    inout  wire  [15:0]              SRAM_DQ
);
    state_t        state, state_nxt;
    logic [3:0]    wait_cnt;
    logic          is_io, start, io_rd, io_wr, kbdr_rd, dq_oe;
    logic [8:0]    io_ofs;
    logic [15:0]   rd_data, kbdr;
    logic          kb_ready, kb_ovr;
    logic [NUM_DISP-1:0] ddr_wr;
    logic [15:0]   ddr [NUM_DISP];
    logic [15:0]   dsr [NUM_DISP];

    assign is_io   = bus.Addr >= IO_BASE;
    assign io_ofs  = 9'(bus.Addr - IO_BASE);
    assign start   = (state == IDLE) && bus.Mem_Req;
    assign io_rd   = start && is_io && !bus.Mem_RW;
    assign io_wr   = start && is_io && bus.Mem_RW;
    assign kbdr_rd = io_rd && (io_ofs == KBDR_OFS);

    // IO register decode: read mux and per-channel DDR write enables.
    always_comb begin
        rd_data = '0;
        ddr_wr  = '0;
        if (io_ofs == KBSR_OFS) begin
            rd_data[KBSR_READY]   = kb_ready;
            rd_data[KBSR_OVERRUN] = kb_ovr;
        end else if (io_ofs == KBDR_OFS) begin
            rd_data = kbdr;
        end
        for (int i = 0; i < NUM_DISP; i++) begin
            if (io_ofs == 9'(DISP_BASE_OFS + DISP_STRIDE * i))
                rd_data = dsr[i];
            if (io_ofs == 9'(DISP_BASE_OFS + DISP_STRIDE * i + 2)) begin
                rd_data   = ddr[i];
                ddr_wr[i] = io_wr;
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.Mem_Req) state_nxt = is_io ? DONE : SRAM_ACC;
            SRAM_ACC: if (wait_cnt == '0) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode: handshake and active-low SRAM controls.
    always_comb begin
        bus.Mem_Ready = (state == DONE);
        SRAM_CE_N     = 1'b1;
        SRAM_OE_N     = 1'b1;
        SRAM_WE_N     = 1'b1;
        SRAM_LB_N     = 1'b1;
        SRAM_UB_N     = 1'b1;
        SRAM_ADDR     = '0;
        dq_oe         = 1'b0;
        if (state == SRAM_ACC) begin
            SRAM_CE_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_ADDR = SRAM_ADDR_W'(bus.Addr);
            if (bus.Mem_RW) begin
                SRAM_WE_N = 1'b0;
                dq_oe     = 1'b1;
            end else begin
                SRAM_OE_N = 1'b0;
            end
        end
    end

    assign SRAM_DQ = dq_oe ? bus.Data_FromCPU : 16'bz;

    // SRAM wait-state down-counter, loaded as the access starts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            wait_cnt <= '0;
        else if (start && !is_io)
            wait_cnt <= 4'(SRAM_WAIT);
        else if (state == SRAM_ACC && wait_cnt != '0)
            wait_cnt <= wait_cnt - 4'd1;
    end

    // Read data register; holds between reads.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            bus.Data_ToCPU <= '0;
        else if (io_rd)
            bus.Data_ToCPU <= rd_data;
        else if (state == SRAM_ACC && wait_cnt == '0 && !bus.Mem_RW)
            bus.Data_ToCPU <= SRAM_DQ;
    end

    // Keyboard: a strobe always wins ready; a coincident KBDR read cancels overrun.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            kbdr     <= '0;
            kb_ready <= 1'b0;
            kb_ovr   <= 1'b0;
        end else if (Kbd_Strobe) begin
            kbdr     <= Kbd_Data;
            kb_ready <= 1'b1;
            kb_ovr   <= kbdr_rd ? 1'b0 : (kb_ovr | kb_ready);
        end else if (kbdr_rd) begin
            kb_ready <= 1'b0;
            kb_ovr   <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_DISP; i++) begin : g_disp
        elc3_disp_chan #(.DISP_BUSY(DISP_BUSY)) u_chan (
            .Clk     (Clk),
            .Reset   (Reset),
            .wr_en   (ddr_wr[i]),
            .wr_data (bus.Data_FromCPU),
            .ddr     (ddr[i]),
            .dsr     (dsr[i]),
            .strobe  (Disp_Strobe[i])
        );
        assign Disp_Out[16*i +: 16] = ddr[i];
    end
endmodule

// File: tb/tb_elc3_mmio_ctrl.sv
// Randomized bench for elc3_mmio_ctrl against a transaction-level reference model.
module tb_elc3_mmio_ctrl;
    import elc3_mmio_pkg::*;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_WAIT   = 2;
    localparam int NUM_DISP    = 2;
    localparam int DISP_BUSY   = 4;

    localparam int K_SRAM = 0, K_KBSR = 1, K_KBDR = 2, K_DSR = 3, K_DDR = 4, K_NONE = 5;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] kbd_data;
    logic kbd_strobe;
    logic [16*NUM_DISP-1:0] disp_out;
    logic [NUM_DISP-1:0] disp_strobe;
    logic ce_n, oe_n, we_n, lb_n, ub_n;
    logic [SRAM_ADDR_W-1:0] sram_addr;
    wire  [15:0] sram_dq;

    elc3_mmio_ctrl_if bus ();

    elc3_mmio_ctrl #(
        .SRAM_ADDR_W(SRAM_ADDR_W), .SRAM_WAIT(SRAM_WAIT),
        .NUM_DISP(NUM_DISP), .DISP_BUSY(DISP_BUSY)
    ) dut (
        .Clk(clk), .Reset(rst), .bus(bus),
        .Kbd_Data(kbd_data), .Kbd_Strobe(kbd_strobe),
        .Disp_Out(disp_out), .Disp_Strobe(disp_strobe),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
        .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple asynchronous SRAM device.
    logic [15:0] sram_mem [0:1023];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr[9:0]] : 16'bz;
    always @(posedge clk) if (!ce_n && !we_n) sram_mem[sram_addr[9:0]] <= sram_dq;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [15:0] ref_mem [0:1023];
    logic [15:0] kb_data;
    bit          kb_rdy, kb_ovr;
    logic [15:0] ddr_m [NUM_DISP];
    int          wcyc  [NUM_DISP];
    logic [15:0] last_rd;
    logic [15:0] op_rd;
    int          op_lat, op_cec;
    logic [NUM_DISP-1:0] op_strb;

    function automatic int dev_of(input logic [15:0] a, output int idx);
        int ofs;
        idx = 0;
        if (a < 16'hFE00) return K_SRAM;
        ofs = int'(a) - 'hFE00;
        if (ofs == 0) return K_KBSR;
        if (ofs == 2) return K_KBDR;
        if (ofs >= 4 && ofs < 4 + 4 * NUM_DISP) begin
            idx = (ofs - 4) / 4;
            if (ofs % 4 == 0) return K_DSR;
            if (ofs % 4 == 2) return K_DDR;
        end
        return K_NONE;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a, input int s);
        int idx, kind, age;
        kind = dev_of(a, idx);
        case (kind)
            K_SRAM: return ref_mem[a[9:0]];
            K_KBSR: return {kb_rdy, kb_ovr, 14'd0};
            K_KBDR: return kb_data;
            K_DSR: begin
                age = s - wcyc[idx];
                return (age >= 1 && age <= DISP_BUSY) ? 16'h0000 : 16'h8000;
            end
            K_DDR:  return ddr_m[idx];
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        kb_data = '0; kb_rdy = 0; kb_ovr = 0; last_rd = '0;
        for (int i = 0; i < NUM_DISP; i++) begin
            ddr_m[i] = '0;
            wcyc[i]  = -1000;
        end
    endtask

    task automatic kb_event(input logic [15:0] d);
        kb_ovr  = kb_ovr | kb_rdy;
        kb_rdy  = 1;
        kb_data = d;
    endtask

    // All tasks start and end at a negedge with the DUT idle.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic kbd_pulse(input logic [15:0] d);
        kbd_data = d; kbd_strobe = 1;
        @(negedge clk);
        kbd_strobe = 0;
        kb_event(d);
    endtask

    task automatic access(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                          input bit ks, input logic [15:0] kd,
                          output logic [15:0] rd, output int lat, output int cec,
                          output int bctl, output logic [NUM_DISP-1:0] strb, output int s);
        bit done = 0;
        bus.Mem_Req = 1; bus.Mem_RW = rw; bus.Addr = a; bus.Data_FromCPU = wd;
        if (ks) begin kbd_data = kd; kbd_strobe = 1; end
        s = cyc + 1;
        lat = 0; cec = 0; bctl = 0; rd = '0; strb = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            kbd_strobe = 0;
            lat++;
            if (!ce_n) begin
                cec++;
                if (sram_addr !== SRAM_ADDR_W'(a) || lb_n !== 1'b0 || ub_n !== 1'b0) bctl++;
                if (rw) begin
                    if (we_n !== 1'b0 || oe_n !== 1'b1 || dut.dq_oe !== 1'b1 || sram_dq !== wd) bctl++;
                end else if (oe_n !== 1'b0 || we_n !== 1'b1 || dut.dq_oe !== 1'b0) bctl++;
            end else if (oe_n !== 1'b1 || we_n !== 1'b1 || lb_n !== 1'b1 || ub_n !== 1'b1 ||
                         sram_addr !== '0 || dut.dq_oe !== 1'b0) begin
                bctl++;
            end
            if (bus.Mem_Ready === 1'b1) begin
                rd = bus.Data_ToCPU; strb = disp_strobe;
                bus.Mem_Req = 0; done = 1;
            end
        end
        if (!done) begin
            chk("ready_timeout", 0, 1);
            lat = -1;
            bus.Mem_Req = 0;
        end
    endtask

    task automatic run_op(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                          input bit ks = 0, input logic [15:0] kd = 16'h0);
        logic [15:0] rd, exp_rd;
        int lat, cec, bctl, s, idx, kind;
        logic [NUM_DISP-1:0] strb, exp_strb;
        logic [16*NUM_DISP-1:0] exp_do;
        kind = dev_of(a, idx);
        access(rw, a, wd, ks, kd, rd, lat, cec, bctl, strb, s);
        exp_rd = rw ? last_rd : model_read(a, s);
        chk("rdata", rd, exp_rd);
        chk("latency", lat, (kind == K_SRAM) ? SRAM_WAIT + 2 : 1);
        chk("ce_cycles", cec, (kind == K_SRAM) ? SRAM_WAIT + 1 : 0);
        chk("sram_ctl", bctl, 0);
        exp_strb = (rw && kind == K_DDR) ? NUM_DISP'(1) << idx : '0;
        chk("disp_strobe", strb, exp_strb);
        if (!rw && kind == K_KBDR) begin kb_rdy = 0; kb_ovr = 0; end
        if (rw && kind == K_DDR) begin ddr_m[idx] = wd; wcyc[idx] = s; end
        if (rw && kind == K_SRAM) ref_mem[a[9:0]] = wd;
        if (ks) kb_event(kd);
        last_rd = exp_rd;
        for (int i = 0; i < NUM_DISP; i++) exp_do[16*i +: 16] = ddr_m[i];
        chk("disp_out", disp_out, exp_do);
        op_rd = rd; op_lat = lat; op_cec = cec; op_strb = strb;
        @(negedge clk);
        chk("ready_pulse", bus.Mem_Ready, 0);
        chk("strobe_clear", disp_strobe, 0);
    endtask

    initial begin
        logic [15:0] a;
        int r;
        rst = 1; kbd_data = '0; kbd_strobe = 0;
        bus.Mem_Req = 0; bus.Mem_RW = 0; bus.Addr = '0; bus.Data_FromCPU = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_ready", bus.Mem_Ready, 0);
        chk("rst_rdata", bus.Data_ToCPU, 0);
        chk("rst_ctl", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
        chk("rst_addr", sram_addr, 0);
        chk("rst_dq_oe", dut.dq_oe, 0);
        chk("rst_disp_out", disp_out, 0);
        chk("rst_disp_strobe", disp_strobe, 0);
        rst = 0;
        @(negedge clk);

        // SRAM write then read at 0x0040.
        run_op(1, 16'h0040, 16'h1234);
        chk("plan_sram_wlat", op_lat, 4);
        chk("plan_sram_wce", op_cec, 3);
        run_op(0, 16'h0040, 16'h0);
        chk("plan_sram_rd", op_rd, 16'h1234);
        chk("plan_sram_rlat", op_lat, 4);

        // Keyboard overrun then clear.
        kbd_pulse(16'h00AB);
        kbd_pulse(16'h00CD);
        run_op(0, 16'hFE00, 16'h0); chk("plan_kbsr_ovr", op_rd, 16'hC000);
        run_op(0, 16'hFE02, 16'h0); chk("plan_kbdr", op_rd, 16'h00CD);
        run_op(0, 16'hFE00, 16'h0); chk("plan_kbsr_clr", op_rd, 16'h0000);

        // Strobe coincident with KBDR read.
        kbd_pulse(16'h0011);
        run_op(0, 16'hFE02, 16'h0, 1, 16'h0022); chk("plan_kb_coinc_old", op_rd, 16'h0011);
        run_op(0, 16'hFE00, 16'h0); chk("plan_kb_coinc_sr", op_rd, 16'h8000);
        run_op(0, 16'hFE02, 16'h0); chk("plan_kb_coinc_new", op_rd, 16'h0022);

        // Display channel 1 write and busy window.
        run_op(1, 16'hFE0A, 16'hBEEF);
        chk("plan_ddr1", disp_out[31:16], 16'hBEEF);
        chk("plan_strobe1", op_strb, 2'b10);
        run_op(0, 16'hFE08, 16'h0); chk("plan_dsr1_busy", op_rd, 16'h0000);
        idle(1);
        run_op(0, 16'hFE08, 16'h0); chk("plan_dsr1_ready", op_rd, 16'h8000);
        run_op(0, 16'hFE04, 16'h0); chk("plan_dsr0", op_rd, 16'h8000);
        run_op(1, 16'hFE0A, 16'h5555);
        run_op(0, 16'hFE08, 16'h0);
        run_op(0, 16'hFE08, 16'h0); chk("plan_dsr1_last_busy", op_rd, 16'h0000);

        // Unmapped IO.
        run_op(0, 16'hFE0A, 16'h0);
        run_op(0, 16'hFE20, 16'h0);
        chk("plan_unmapped_rd", op_rd, 16'h0000);
        chk("plan_unmapped_lat", op_lat, 1);
        chk("plan_unmapped_ce", op_cec, 0);
        run_op(1, 16'hFE20, 16'hFFFF);

        // Reset in the middle of an SRAM write, with DSR_0 busy.
        run_op(1, 16'hFE06, 16'h0F0F);
        bus.Mem_Req = 1; bus.Mem_RW = 1; bus.Addr = 16'h0100; bus.Data_FromCPU = 16'hA5A5;
        @(negedge clk);
        chk("mid_we_low", we_n, 0);
        #2 rst = 1;
        #1;
        chk("mid_rst_we", we_n, 1);
        chk("mid_rst_ce", ce_n, 1);
        chk("mid_rst_dq_oe", dut.dq_oe, 0);
        chk("mid_rst_state", dut.state, IDLE);
        chk("mid_rst_dsr0", dut.dsr[0], 16'h8000);
        chk("mid_rst_rdata", bus.Data_ToCPU, 0);
        chk("mid_rst_disp", disp_out, 0);
        bus.Mem_Req = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        run_op(0, 16'hFE04, 16'h0); chk("post_rst_dsr0", op_rd, 16'h8000);

        // Randomized phase: seed the SRAM pool, then mixed traffic.
        for (int i = 0; i < 128; i++) run_op(1, 16'(i), 16'($urandom));
        for (int n = 0; n < 300; n++) begin
            idle($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                kbd_pulse(16'($urandom));
            end else begin
                if (r <= 4)      a = 16'($urandom_range(0, 127));
                else if (r <= 7) a = 16'(16'hFE00 + $urandom_range(0, 15));
                else             a = 16'(16'hFE00 + $urandom_range(0, 511));
                run_op(1'($urandom_range(0, 1)), a, 16'($urandom),
                       ($urandom_range(0, 5) == 0), 16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
